uart_xcvr_core: RTL and testbench
=================================

Name: uart_xcvr_core

Overview:
- Synthesizable, parametrised UART transceiver for the peripheral subsystem. Used as a DUT-side UART core and as a cycle-accurate bench model.
- Configurable frame format: 5–8 data bits, optional parity, 1 or 2 stop bits.
- 16x-oversampled receiver with start-glitch rejection, parametrised RX FIFO, character timeout, and saturating error counters.
- Transmitter uses a valid/ready byte interface.

Parameters:
- RX_FIFO_DEPTH, 8, RX FIFO entries; power of 2, 2..64.
- CNT_W, 16, width of the error/character counters.
- DIV_W, 16, width of the baud divisor.

Ports:
- mclk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cfg_divisor  in  DIV_W  16x tick every (cfg_divisor+1) mclk cycles
- cfg_data_bits  in  2  data bits = value+5
- cfg_parity_en  in  1  parity bit present
- cfg_even_par  in  1  1=even, 0=odd
- cfg_stop2  in  1  two stop bits
- cfg_timeout  in  8  RX idle timeout in bit periods; 0 disables
- tx_data  in  8  byte to send
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  transmitter idle, can accept
- txd  out  1  serial out
- rxd  in  1  serial in (asynchronous)
- rx_data  out  8  FIFO head data
- rx_err  out  2  FIFO head {parity_err, framing_err}
- rx_valid  out  1  FIFO non-empty
- rx_pop  in  1  pop head when rx_valid
- rx_timeout  out  1  sticky timeout flag
- cnt_clr  in  1  clear all counters and rx_timeout
- rx_cnt, tx_cnt, par_err_cnt, frm_err_cnt, ovr_cnt  out  CNT_W each  statistics

Behaviour:
- Reset values: txd=1, tx_ready=1, rx_valid=0, rx_data=0, rx_err=0, rx_timeout=0, all counters 0, FIFO empty, both FSMs IDLE.
- Baud tick: free-running counter 0..cfg_divisor. Bit period = 16 ticks = 16*(cfg_divisor+1) mclk cycles. TX and RX keep independent 4-bit phase counters.
- Config inputs are latched per frame: TX at accept, RX at start detect. Changes mid-frame have no effect on that frame.
- TX handshake: accept when tx_valid && tx_ready.
  - tx_ready drops the cycle after accept.
  - txd=0 from the cycle after accept for one bit period.
- TX FSM: IDLE→START→DATA (LSB first, N bits)→PARITY (if enabled)→STOP1→STOP2 (if cfg_stop2)→IDLE.
  - Parity bit = XOR(data) when even, ~XOR(data) when odd.
  - Data bits above N are ignored.
  - tx_ready rises the cycle after the last stop bit ends. Back-to-back frames have no idle gap.
- RX input: rxd passes through a 2-flop synchronizer, sync reset to 1.
- RX FSM:
  - IDLE: falling edge of synced rxd → START; phase counter cleared.
  - START: at phase 7, if rxd=1 it is a glitch → IDLE, nothing counted. Otherwise → DATA.
  - DATA: sample at phase 7 of each bit; bits shift into [N-1:0]; upper bits read 0.
  - PARITY: parity_err when the received bit ≠ expected parity.
  - STOP1: framing_err when the sample is 0.
  - STOP2: framing_err when the sample is 0.
  - Push, then → IDLE right after the last stop sample at phase 7. A new start edge is accepted from the next cycle.
- Push rules:
  - If the FIFO is not full, write {par_err, frm_err, data}; rx_cnt++; par_err_cnt/frm_err_cnt increment per flag.
  - If the FIFO is full, drop the frame; ovr_cnt++; rx_cnt is not incremented.
  - Push and pop in the same cycle when full: the pop frees the slot and the push is stored (no overrun).
- FIFO output: first-word-fall-through; rx_data/rx_err show the head while rx_valid=1. rx_pop while empty is ignored.
- tx_cnt increments when a TX frame completes.
- Counters saturate at all-ones. cnt_clr has priority over a same-cycle increment.
- Timeout:
  - While rx_valid=1 and RX is IDLE, count elapsed bit periods.
  - Reaching cfg_timeout sets rx_timeout, which stays set until cnt_clr or rst.
  - Count restarts on any start edge or pop. Disabled when cfg_timeout=0.
- rst mid-frame: both FSMs abort and FIFO contents are lost; txd=1 on the next cycle.

Optional Feature:
- UART_LOOPBACK_EN defined: adds input port cfg_loopback.
  - When cfg_loopback=1, the receiver input is internally txd (bypassing the synchronizer stage 1 is not allowed; loopback goes through both flops).
  - External txd is held at 1; rxd is ignored.
- Undefined: no port, no mux; receiver always uses rxd.

Test Plan:
- Common bench setup: divisor=0 (16-cycle bit), 8N1.
- Send tx_data=0xA5 → txd pattern 0,1,0,1,0,0,1,0,1,1, each held 16 cycles. tx_ready high again 160 cycles after accept; tx_cnt=1.
- Bench drives 0x3C on rxd with 7E2 (parity_en=1, even=1, stop2=1) and correct parity → rx_valid, rx_data=0x3C, rx_err=00. Repeat with the parity bit flipped → rx_err=10, par_err_cnt=1.
- Low pulse of 5 cycles on rxd → no push, rx_cnt unchanged. Then stop bit driven 0 → rx_err=01, frm_err_cnt=1.
- DEPTH=8: send 10 frames without popping → 8 stored, ovr_cnt=2. Pop all → data in order of frames 1..8.
- cfg_timeout=4: one frame received, not popped → rx_timeout set after 64 idle cycles. cnt_clr → all counters and rx_timeout cleared.
- Assert rst mid-TX (bit 3) → txd=1 and tx_ready=1 next cycle. UART_LOOPBACK_EN with cfg_loopback=1: send 0x5A → received 0x5A, external txd stays 1.

Source files
------------

// File: rtl/uart_xcvr_core_if.sv
// Byte-level handshake bundle of the UART core: TX valid/ready input side and
// the first-word-fall-through RX FIFO head.
interface uart_xcvr_core_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic [1:0] rx_err;
  logic       rx_valid;
  logic       rx_pop;

  modport master (output tx_data, tx_valid, rx_pop,
                  input  tx_ready, rx_data, rx_err, rx_valid);
  modport slave  (input  tx_data, tx_valid, rx_pop,
                  output tx_ready, rx_data, rx_err, rx_valid);
endinterface

// File: rtl/uart_xcvr_core.sv
// UART transceiver: 16x oversampled RX with FIFO, timeout and saturating stats.
// Define UART_LOOPBACK_EN to add cfg_loopback (internal txd -> receiver path).
module uart_xcvr_core #(
  parameter int RX_FIFO_DEPTH = 8,
  parameter int CNT_W         = 16,
  parameter int DIV_W         = 16
) (
  input  logic             mclk,
  input  logic             rst,
  uart_xcvr_core_if.slave  bus,
  input  logic [DIV_W-1:0] cfg_divisor,
  input  logic [1:0]       cfg_data_bits,
  input  logic             cfg_parity_en,
  input  logic             cfg_even_par,
  input  logic             cfg_stop2,
  input  logic [7:0]       cfg_timeout,
`ifdef UART_LOOPBACK_EN
  input  logic             cfg_loopback,
`endif
  output logic             txd,
  input  logic             rxd,
  output logic             rx_timeout,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] rx_cnt,
  output logic [CNT_W-1:0] tx_cnt,
  output logic [CNT_W-1:0] par_err_cnt,
  output logic [CNT_W-1:0] frm_err_cnt,
  output logic [CNT_W-1:0] ovr_cnt
);
  localparam int AW = $clog2(RX_FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP1, S_STOP2} state_t;

  // ---------------- baud tick ----------------
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick;
  always_comb begin
    tick  = (div_q >= cfg_divisor);
    div_d = tick ? '0 : div_q + 1'b1;
  end

  // ---------------- transmitter ----------------
  state_t     tx_st_q;
  logic [3:0] tx_ph_q;
  logic [2:0] tx_bit_q, tx_last_q;
  logic [7:0] tx_sh_q, tx_mask, tx_masked;
  logic       tx_par_q, tx_pen_q, tx_s2_q, txd_q, tx_rdy_q;
  logic       tx_bit_end, tx_done;

  always_comb begin
    tx_mask    = 8'hff >> (2'd3 - cfg_data_bits);
    tx_masked  = bus.tx_data & tx_mask;
    tx_bit_end = tick && (tx_ph_q == 4'hf);
    tx_done    = tx_bit_end && ((tx_st_q == S_STOP1 && !tx_s2_q) || tx_st_q == S_STOP2);
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      tx_st_q <= S_IDLE; tx_ph_q <= '0; tx_bit_q <= '0; tx_last_q <= '0;
      tx_sh_q <= '0; tx_par_q <= 1'b0; tx_pen_q <= 1'b0; tx_s2_q <= 1'b0;
      txd_q   <= 1'b1; tx_rdy_q <= 1'b1;
    end else begin
      if (tick && tx_st_q != S_IDLE) tx_ph_q <= tx_ph_q + 4'd1;
      case (tx_st_q)
        S_IDLE: if (bus.tx_valid) begin
          tx_st_q   <= S_START;
          tx_rdy_q  <= 1'b0;
          txd_q     <= 1'b0;
          tx_ph_q   <= '0;
          tx_sh_q   <= tx_masked;
          tx_last_q <= {1'b1, cfg_data_bits};
          tx_par_q  <= ^tx_masked ^ ~cfg_even_par;
          tx_pen_q  <= cfg_parity_en;
          tx_s2_q   <= cfg_stop2;
        end
        S_START: if (tx_bit_end) begin
          tx_st_q <= S_DATA; txd_q <= tx_sh_q[0]; tx_sh_q <= tx_sh_q >> 1; tx_bit_q <= '0;
        end
        S_DATA: if (tx_bit_end) begin
          if (tx_bit_q == tx_last_q) begin
            tx_st_q <= tx_pen_q ? S_PAR : S_STOP1;
            txd_q   <= tx_pen_q ? tx_par_q : 1'b1;
          end else begin
            txd_q <= tx_sh_q[0]; tx_sh_q <= tx_sh_q >> 1; tx_bit_q <= tx_bit_q + 3'd1;
          end
        end
        S_PAR:   if (tx_bit_end) begin tx_st_q <= S_STOP1; txd_q <= 1'b1; end
        S_STOP1: if (tx_bit_end) begin
          tx_st_q <= tx_s2_q ? S_STOP2 : S_IDLE; tx_rdy_q <= !tx_s2_q;
        end
        S_STOP2: if (tx_bit_end) begin tx_st_q <= S_IDLE; tx_rdy_q <= 1'b1; end
        default: tx_st_q <= S_IDLE;
      endcase
    end
  end

  // ---------------- receiver input path ----------------
  logic       rx_in;
`ifdef UART_LOOPBACK_EN
  assign rx_in = cfg_loopback ? txd_q : rxd;
  assign txd   = cfg_loopback ? 1'b1 : txd_q;
`else
  assign rx_in = rxd;
  assign txd   = txd_q;
`endif

  // [0],[1] synchronizer, [2] previous synced value for edge detect
  logic [2:0] rx_sync_q, rx_sync_d;
  logic       rx_bit, rx_fall;
  always_comb begin
    rx_sync_d = {rx_sync_q[1:0], rx_in};
    rx_bit    = rx_sync_q[1];
    rx_fall   = rx_sync_q[2] && !rx_sync_q[1];
  end

  // ---------------- receiver FSM ----------------
  state_t     rx_st_q;
  logic [3:0] rx_ph_q;
  logic [2:0] rx_bit_q, rx_last_q;
  logic [7:0] rx_sh_q;
  logic       rx_pen_q, rx_even_q, rx_s2_q, rx_perr_q, rx_ferr_q;
  logic       rx_smp, rx_start, push, push_ferr;

  always_comb begin
    rx_smp    = tick && (rx_ph_q == 4'd7);
    rx_start  = (rx_st_q == S_IDLE) && rx_fall;
    push      = rx_smp && ((rx_st_q == S_STOP1 && !rx_s2_q) || rx_st_q == S_STOP2);
    push_ferr = rx_ferr_q | ~rx_bit;
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      rx_st_q <= S_IDLE; rx_ph_q <= '0; rx_bit_q <= '0; rx_last_q <= '0; rx_sh_q <= '0;
      rx_pen_q <= 1'b0; rx_even_q <= 1'b0; rx_s2_q <= 1'b0; rx_perr_q <= 1'b0; rx_ferr_q <= 1'b0;
    end else begin
      if (tick && rx_st_q != S_IDLE) rx_ph_q <= rx_ph_q + 4'd1;
      case (rx_st_q)
        S_IDLE: if (rx_fall) begin
          rx_st_q   <= S_START; rx_ph_q <= '0; rx_sh_q <= '0;
          rx_perr_q <= 1'b0;    rx_ferr_q <= 1'b0;
          rx_last_q <= {1'b1, cfg_data_bits};
          rx_pen_q  <= cfg_parity_en; rx_even_q <= cfg_even_par; rx_s2_q <= cfg_stop2;
        end
        S_START: if (rx_smp) begin
          rx_st_q  <= rx_bit ? S_IDLE : S_DATA;
          rx_bit_q <= '0;
        end
        S_DATA: if (rx_smp) begin
          rx_sh_q[rx_bit_q] <= rx_bit;
          if (rx_bit_q == rx_last_q) rx_st_q <= rx_pen_q ? S_PAR : S_STOP1;
          else                       rx_bit_q <= rx_bit_q + 3'd1;
        end
        S_PAR: if (rx_smp) begin
          rx_perr_q <= rx_bit != (^rx_sh_q ^ ~rx_even_q);
          rx_st_q   <= S_STOP1;
        end
        S_STOP1: if (rx_smp) begin
          rx_ferr_q <= push_ferr;
          rx_st_q   <= rx_s2_q ? S_STOP2 : S_IDLE;
        end
        S_STOP2: if (rx_smp) rx_st_q <= S_IDLE;
        default: rx_st_q <= S_IDLE;
      endcase
    end
  end

  // ---------------- RX FIFO ----------------
  logic [9:0] mem_q [RX_FIFO_DEPTH];
  logic [AW:0] wp_q, wp_d, rp_q, rp_d;
  logic        empty, full, pop_ok, push_ok, ovr;
  logic [9:0]  head;

  always_comb begin
    empty   = (wp_q == rp_q);
    full    = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    pop_ok  = bus.rx_pop && !empty;
    // a same-cycle pop frees the slot the push needs
    push_ok = push && (!full || pop_ok);
    ovr     = push && full && !pop_ok;
    wp_d    = wp_q + {{AW{1'b0}}, push_ok};
    rp_d    = rp_q + {{AW{1'b0}}, pop_ok};
    head    = mem_q[rp_q[AW-1:0]];
  end

  always_ff @(posedge mclk)
    if (push_ok) mem_q[wp_q[AW-1:0]] <= {rx_perr_q, push_ferr, rx_sh_q};

  assign bus.rx_valid = !empty;
  assign bus.rx_data  = empty ? 8'd0 : head[7:0];
  assign bus.rx_err   = empty ? 2'd0 : head[9:8];
  assign bus.tx_ready = tx_rdy_q;

  // ---------------- statistics: 0 rx, 1 tx, 2 par, 3 frm, 4 ovr ----------------
  logic [4:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]            inc;
  always_comb begin
    inc = {ovr, push_ok && push_ferr, push_ok && rx_perr_q, tx_done, push_ok};
    for (int i = 0; i < 5; i++) begin
      cnt_d[i] = cnt_q[i];
      if (cnt_clr)                     cnt_d[i] = '0;
      else if (inc[i] && !(&cnt_q[i])) cnt_d[i] = cnt_q[i] + 1'b1;
    end
  end
  assign rx_cnt      = cnt_q[0];
  assign tx_cnt      = cnt_q[1];
  assign par_err_cnt = cnt_q[2];
  assign frm_err_cnt = cnt_q[3];
  assign ovr_cnt     = cnt_q[4];

  // ---------------- idle timeout ----------------
  logic [3:0] to_ph_q, to_ph_d;
  logic [7:0] to_bits_q, to_bits_d;
  logic       to_flag_q, to_flag_d, to_act;
  always_comb begin
    to_act    = bus.rx_valid && (rx_st_q == S_IDLE) && (cfg_timeout != 8'd0);
    to_ph_d   = to_ph_q;
    to_bits_d = to_bits_q;
    to_flag_d = to_flag_q;
    if (rx_start || pop_ok || !to_act) begin
      to_ph_d = '0; to_bits_d = '0;
    end else if (tick) begin
      to_ph_d = to_ph_q + 4'd1;
      if (to_ph_q == 4'hf) begin
        if (to_bits_q != 8'hff) to_bits_d = to_bits_q + 8'd1;
        if (to_bits_q + 8'd1 == cfg_timeout) to_flag_d = 1'b1;
      end
    end
    if (cnt_clr) to_flag_d = 1'b0;
  end
  assign rx_timeout = to_flag_q;

  always_ff @(posedge mclk) begin
    if (rst) begin
      div_q <= '0; rx_sync_q <= 3'b111; wp_q <= '0; rp_q <= '0; cnt_q <= '0;
      to_ph_q <= '0; to_bits_q <= '0; to_flag_q <= 1'b0;
    end else begin
      div_q <= div_d; rx_sync_q <= rx_sync_d; wp_q <= wp_d; rp_q <= rp_d; cnt_q <= cnt_d;
      to_ph_q <= to_ph_d; to_bits_q <= to_bits_d; to_flag_q <= to_flag_d;
    end
  end
endmodule

// File: tb/tb_uart_xcvr_core.sv
// Directed bench for uart_xcvr_core: TX framing, RX parity/framing/glitch,
// FIFO overrun, idle timeout, mid-frame reset and (optionally) loopback.
module tb_uart_xcvr_core;
  logic        mclk = 1'b0;
  logic        rst  = 1'b1;
  logic [15:0] cfg_divisor = '0;
  logic [1:0]  cfg_data_bits = 2'd3;
  logic        cfg_parity_en = 1'b0, cfg_even_par = 1'b0, cfg_stop2 = 1'b0;
  logic [7:0]  cfg_timeout = '0;
  logic        txd, rxd = 1'b1, rx_timeout, cnt_clr = 1'b0;
  logic [15:0] rx_cnt, tx_cnt, par_err_cnt, frm_err_cnt, ovr_cnt;
`ifdef UART_LOOPBACK_EN
  logic        cfg_loopback = 1'b0;
`endif
  int checks = 0, errors = 0;

  uart_xcvr_core_if bus();

  uart_xcvr_core #(.RX_FIFO_DEPTH(8), .CNT_W(16), .DIV_W(16)) dut (
    .mclk(mclk), .rst(rst), .bus(bus),
    .cfg_divisor(cfg_divisor), .cfg_data_bits(cfg_data_bits),
    .cfg_parity_en(cfg_parity_en), .cfg_even_par(cfg_even_par),
    .cfg_stop2(cfg_stop2), .cfg_timeout(cfg_timeout),
`ifdef UART_LOOPBACK_EN
    .cfg_loopback(cfg_loopback),
`endif
    .txd(txd), .rxd(rxd), .rx_timeout(rx_timeout), .cnt_clr(cnt_clr),
    .rx_cnt(rx_cnt), .tx_cnt(tx_cnt), .par_err_cnt(par_err_cnt),
    .frm_err_cnt(frm_err_cnt), .ovr_cnt(ovr_cnt)
  );

  always #5 mclk = ~mclk;

  task automatic step(input int n);
    repeat (n) @(posedge mclk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] d, input int nb, input logic pen,
                         input logic pbit, input logic stop_val, input int nstop);
    rxd = 1'b0; step(16);
    for (int i = 0; i < nb; i++) begin rxd = d[i]; step(16); end
    if (pen) begin rxd = pbit; step(16); end
    for (int s = 0; s < nstop; s++) begin rxd = stop_val; step(16); end
    rxd = 1'b1;
  endtask

  task automatic pop();
    bus.rx_pop = 1'b1; step(1); bus.rx_pop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; step(3); rst = 1'b0; step(1);
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd got %b want 1", txd); end
    checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready got %b want 1", bus.tx_ready); end
    checks++; if ({bus.rx_valid, bus.rx_data, bus.rx_err, rx_timeout} !== 12'd0) begin errors++;
      $display("FAIL reset_rx got %b/%h/%b/%b want 0", bus.rx_valid, bus.rx_data, bus.rx_err, rx_timeout); end
    checks++; if ({rx_cnt, tx_cnt, par_err_cnt, frm_err_cnt, ovr_cnt} !== 80'd0) begin errors++;
      $display("FAIL reset_counters got %h %h %h %h %h want 0", rx_cnt, tx_cnt, par_err_cnt, frm_err_cnt, ovr_cnt); end
  endtask

  task automatic test_tx();
    logic [9:0] pat;
    pat = {1'b1, 8'hA5, 1'b0};
    bus.tx_data = 8'hA5; bus.tx_valid = 1'b1; step(1); bus.tx_valid = 1'b0;
    checks++; if (bus.tx_ready !== 1'b0) begin errors++; $display("FAIL tx_ready_drop got %b want 0", bus.tx_ready); end
    for (int i = 0; i < 10; i++) begin
      step(8);
      checks++; if (txd !== pat[i]) begin errors++; $display("FAIL tx_bit%0d got %b want %b", i, txd, pat[i]); end
      step(8);
    end
    checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL tx_ready_160 got %b want 1", bus.tx_ready); end
    checks++; if (tx_cnt !== 16'd1) begin errors++; $display("FAIL tx_cnt got %0d want 1", tx_cnt); end
  endtask

  task automatic test_rx_parity();
    cfg_data_bits = 2'd2; cfg_parity_en = 1'b1; cfg_even_par = 1'b1; cfg_stop2 = 1'b1;
    send_rx(8'h3C, 7, 1'b1, 1'b0, 1'b1, 2); step(2);
    checks++; if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'h3C || bus.rx_err !== 2'b00) begin errors++;
      $display("FAIL rx_7e2_good got %b/%h/%b want 1/3c/00", bus.rx_valid, bus.rx_data, bus.rx_err); end
    pop();
    send_rx(8'h3C, 7, 1'b1, 1'b1, 1'b1, 2); step(2);
    checks++; if (bus.rx_data !== 8'h3C || bus.rx_err !== 2'b10) begin errors++;
      $display("FAIL rx_7e2_bad_par got %h/%b want 3c/10", bus.rx_data, bus.rx_err); end
    checks++; if (par_err_cnt !== 16'd1) begin errors++; $display("FAIL par_err_cnt got %0d want 1", par_err_cnt); end
    pop();
    cfg_data_bits = 2'd3; cfg_parity_en = 1'b0; cfg_even_par = 1'b0; cfg_stop2 = 1'b0;
  endtask

  task automatic test_glitch_framing();
    rxd = 1'b0; step(5); rxd = 1'b1; step(40);
    checks++; if (bus.rx_valid !== 1'b0 || rx_cnt !== 16'd2) begin errors++;
      $display("FAIL glitch got valid=%b rx_cnt=%0d want 0/2", bus.rx_valid, rx_cnt); end
    send_rx(8'h55, 8, 1'b0, 1'b0, 1'b0, 1); step(2);
    checks++; if (bus.rx_data !== 8'h55 || bus.rx_err !== 2'b01) begin errors++;
      $display("FAIL rx_frm got %h/%b want 55/01", bus.rx_data, bus.rx_err); end
    checks++; if (frm_err_cnt !== 16'd1) begin errors++; $display("FAIL frm_err_cnt got %0d want 1", frm_err_cnt); end
    pop();
  endtask

  task automatic test_overrun();
    logic [7:0] e;
    for (int i = 1; i <= 10; i++) begin
      e = 8'(8'h11 * i);
      send_rx(e, 8, 1'b0, 1'b0, 1'b1, 1);
    end
    step(4);
    checks++; if (ovr_cnt !== 16'd2) begin errors++; $display("FAIL ovr_cnt got %0d want 2", ovr_cnt); end
    checks++; if (rx_cnt !== 16'd11) begin errors++; $display("FAIL ovr_rx_cnt got %0d want 11", rx_cnt); end
    for (int i = 1; i <= 8; i++) begin
      e = 8'(8'h11 * i);
      checks++; if (bus.rx_valid !== 1'b1 || bus.rx_data !== e) begin errors++;
        $display("FAIL fifo_order%0d got %b/%h want 1/%h", i, bus.rx_valid, bus.rx_data, e); end
      pop();
    end
    checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL fifo_drained got %b want 0", bus.rx_valid); end
  endtask

  task automatic test_timeout();
    cfg_timeout = 8'd4;
    send_rx(8'h81, 8, 1'b0, 1'b0, 1'b1, 1);
    step(40);
    checks++; if (rx_timeout !== 1'b0) begin errors++; $display("FAIL timeout_early got %b want 0", rx_timeout); end
    step(40);
    checks++; if (rx_timeout !== 1'b1) begin errors++; $display("FAIL timeout_set got %b want 1", rx_timeout); end
    cnt_clr = 1'b1; step(1); cnt_clr = 1'b0;
    checks++; if ({rx_timeout, rx_cnt, tx_cnt, par_err_cnt, frm_err_cnt, ovr_cnt} !== 81'd0) begin errors++;
      $display("FAIL cnt_clr got %b %h %h %h %h %h want 0", rx_timeout, rx_cnt, tx_cnt, par_err_cnt, frm_err_cnt, ovr_cnt); end
    step(20);
    checks++; if (rx_timeout !== 1'b0) begin errors++; $display("FAIL timeout_stays_clr got %b want 0", rx_timeout); end
    cfg_timeout = 8'd0;
  endtask

  task automatic test_rst_mid_tx();
    checks++; if (bus.rx_valid !== 1'b1) begin errors++; $display("FAIL pre_rst_fifo got %b want 1", bus.rx_valid); end
    bus.tx_data = 8'h00; bus.tx_valid = 1'b1; step(1); bus.tx_valid = 1'b0;
    step(72);
    checks++; if (txd !== 1'b0 || bus.tx_ready !== 1'b0) begin errors++;
      $display("FAIL mid_tx got txd=%b rdy=%b want 0/0", txd, bus.tx_ready); end
    rst = 1'b1; step(1);
    checks++; if (txd !== 1'b1 || bus.tx_ready !== 1'b1 || bus.rx_valid !== 1'b0) begin errors++;
      $display("FAIL rst_mid_tx got txd=%b rdy=%b valid=%b want 1/1/0", txd, bus.tx_ready, bus.rx_valid); end
    rst = 1'b0; step(2);
  endtask

`ifdef UART_LOOPBACK_EN
  task automatic test_loopback();
    int bad = 0, n = 0;
    cfg_loopback = 1'b1; step(4);
    bus.tx_data = 8'h5A; bus.tx_valid = 1'b1; step(1); bus.tx_valid = 1'b0;
    for (int i = 0; i < 170; i++) begin if (txd !== 1'b1) bad++; step(1); end
    checks++; if (bad != 0) begin errors++; $display("FAIL lb_txd_idle got %0d low cycles want 0", bad); end
    while (bus.rx_valid !== 1'b1 && n < 100) begin step(1); n++; end
    checks++; if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'h5A || bus.rx_err !== 2'b00) begin errors++;
      $display("FAIL lb_rx got %b/%h/%b want 1/5a/00", bus.rx_valid, bus.rx_data, bus.rx_err); end
    pop(); cfg_loopback = 1'b0;
  endtask
`endif

  initial begin
    bus.tx_data = '0; bus.tx_valid = 1'b0; bus.rx_pop = 1'b0;
    test_reset();
    test_tx();
    test_rx_parity();
    test_glitch_framing();
    test_overrun();
    test_timeout();
    test_rst_mid_tx();
`ifdef UART_LOOPBACK_EN
    test_loopback();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
